// File: rtl/fetch_pc_unit.sv
// Instruction-fetch front end: program counter, instruction-memory address and IF/ID register.
// Optional perf counters (fetch_cnt, stall_cnt) exist only when IF_PERF_CNT_EN is defined.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] FLUSH_INSTR = 32'h0000_0000,
  parameter int          CNT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 freeze,
  input  logic                 branch_taken,
  input  logic [31:0]          branch_addr,
  output logic [31:0]          imem_addr,
  input  logic [31:0]          imem_instr,
  output logic [31:0]          if_id_pc,
  output logic [31:0]          if_id_instr,
  output logic                 if_id_valid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0] fetch_cnt,
  output logic [CNT_WIDTH-1:0] stall_cnt
`endif
);

  logic [31:0] pc_p0;
  logic [31:0] pc_plus4_p0;
  logic [31:0] branch_tgt_p0;
  logic [1:0]  unused_branch_lsb;
  logic [31:0] if_id_pc_p1;
  logic [31:0] if_id_instr_p1;
  logic        vld_p1;

  // Stage p0: program counter; branch targets are word-aligned by dropping the low bits
  assign pc_plus4_p0       = pc_p0 + 32'd4;
  assign branch_tgt_p0     = {branch_addr[31:2], 2'b00};
  assign unused_branch_lsb = branch_addr[1:0];
  assign imem_addr         = pc_p0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_p0 <= RESET_PC;
    end else if (branch_taken) begin
      pc_p0 <= branch_tgt_p0;
    end else if (!freeze) begin
      pc_p0 <= pc_plus4_p0;
    end
  end

  // Stage p1: IF/ID register; a redirect flushes the slot, a freeze holds it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_id_pc_p1    <= 32'h0000_0000;
      if_id_instr_p1 <= FLUSH_INSTR;
      vld_p1         <= 1'b0;
    end else if (branch_taken) begin
      if_id_pc_p1    <= 32'h0000_0000;
      if_id_instr_p1 <= FLUSH_INSTR;
      vld_p1         <= 1'b0;
    end else if (!freeze) begin
      if_id_pc_p1    <= pc_plus4_p0;
      if_id_instr_p1 <= imem_instr;
      vld_p1         <= 1'b1;
    end
  end

  assign if_id_pc    = if_id_pc_p1;
  assign if_id_instr = if_id_instr_p1;
  assign if_id_valid = vld_p1;

`ifdef IF_PERF_CNT_EN
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  logic [CNT_WIDTH-1:0] fetch_cnt_p1;
  logic [CNT_WIDTH-1:0] stall_cnt_p1;

  // Stage p1: perf counters, saturating at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_p1 <= '0;
      stall_cnt_p1 <= '0;
    end else if (!branch_taken) begin
      if (freeze) stall_cnt_p1 <= sat_inc(stall_cnt_p1);
      else        fetch_cnt_p1 <= sat_inc(fetch_cnt_p1);
    end
  end

  assign fetch_cnt = fetch_cnt_p1;
  assign stall_cnt = stall_cnt_p1;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Scoreboard bench for fetch_pc_unit: driver pushes model predictions, monitor pops and compares.
// Counter checks are compiled in only when IF_PERF_CNT_EN is defined.
module tb_fetch_pc_unit;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] FLUSH  = 32'hDEAD_0013;
  localparam int          CW     = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        freeze = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_addr = '0;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
`ifdef IF_PERF_CNT_EN
  logic [CW-1:0] fetch_cnt;
  logic [CW-1:0] stall_cnt;
`endif

  fetch_pc_unit #(.RESET_PC(RST_PC), .FLUSH_INSTR(FLUSH), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .freeze(freeze), .branch_taken(branch_taken),
    .branch_addr(branch_addr), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .if_id_pc(if_id_pc), .if_id_instr(if_id_instr), .if_id_valid(if_id_valid)
`ifdef IF_PERF_CNT_EN
    , .fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Instruction memory contents are a fixed scramble of the word index.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] idx;
    idx = {2'b00, a[31:2]};
    return (idx * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction
  assign imem_instr = mem_word(imem_addr);

  typedef struct {
    logic [31:0] addr;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
    int          fcnt;
    int          scnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  // Reference model state, in spec terms
  logic [31:0] m_pc;
  logic [31:0] m_ifpc;
  logic [31:0] m_instr;
  logic        m_valid;
  int          m_fcnt;
  int          m_scnt;
  localparam int CMAX = (1 << CW) - 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, expv);
    end
  endtask

  task automatic model_reset();
    m_pc = RST_PC; m_ifpc = 32'h0; m_instr = FLUSH; m_valid = 1'b0;
    m_fcnt = 0; m_scnt = 0;
  endtask

  // Drive one cycle at the negedge and predict the state after the next rising edge.
  task automatic step(input logic f, input logic b, input logic [31:0] a);
    exp_t e;
    @(negedge clk);
    freeze = f; branch_taken = b; branch_addr = a;
    if (b) begin
      m_pc = a & 32'hFFFF_FFFC;
      m_ifpc = 32'h0; m_instr = FLUSH; m_valid = 1'b0;
    end else if (f) begin
      if (m_scnt < CMAX) m_scnt++;
    end else begin
      m_instr = mem_word(m_pc);
      m_ifpc = m_pc + 32'd4;
      m_valid = 1'b1;
      m_pc = m_pc + 32'd4;
      if (m_fcnt < CMAX) m_fcnt++;
    end
    e.addr = m_pc; e.pc = m_ifpc; e.instr = m_instr; e.valid = m_valid;
    e.fcnt = m_fcnt; e.scnt = m_scnt;
    exp_q.push_back(e);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_addr"},  imem_addr, RST_PC);
    check({tag, "_valid"}, {31'b0, if_id_valid}, 32'h0);
    check({tag, "_pc"},    if_id_pc, 32'h0);
    check({tag, "_instr"}, if_id_instr, FLUSH);
`ifdef IF_PERF_CNT_EN
    check({tag, "_fcnt"}, {{(32-CW){1'b0}}, fetch_cnt}, 32'h0);
    check({tag, "_scnt"}, {{(32-CW){1'b0}}, stall_cnt}, 32'h0);
`endif
  endtask

  // Monitor: every rising edge the DUT presents a new state
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("imem_addr",   imem_addr, e.addr);
        check("if_id_pc",    if_id_pc, e.pc);
        check("if_id_instr", if_id_instr, e.instr);
        check("if_id_valid", {31'b0, if_id_valid}, {31'b0, e.valid});
`ifdef IF_PERF_CNT_EN
        check("fetch_cnt", {{(32-CW){1'b0}}, fetch_cnt}, e.fcnt);
        check("stall_cnt", {{(32-CW){1'b0}}, stall_cnt}, e.scnt);
`endif
      end else if (!rst_n) begin
        check_reset_state("hold_rst");
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic rand_steps(input int n);
    logic f, b;
    logic [31:0] a;
    for (int i = 0; i < n; i++) begin
      f = ($urandom_range(0, 3) == 0);
      b = ($urandom_range(0, 9) == 0);
      a = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                      : 32'($urandom_range(0, 255));
      step(f, b, a);
    end
  endtask

  initial begin
    model_reset();
    #12;
    check_reset_state("reset");
    @(posedge clk); #3; rst_n = 1'b1;

    // Sequential fetch from reset, then a three-cycle freeze at PC=8
    step(0, 0, 0); step(0, 0, 0);
    step(1, 0, 0); step(1, 0, 0); step(1, 0, 0);
    step(0, 0, 0); step(0, 0, 0);
    // Redirect to 0x10, then branch 0x40 taken from PC=0x10
    step(0, 1, 32'h10); step(0, 1, 32'h40); step(0, 0, 0); step(0, 0, 0);
    // Branch with simultaneous freeze, misaligned target
    step(1, 1, 32'h23); step(0, 0, 0);
    // PC wrap at the top of the address space
    step(0, 1, 32'hFFFF_FFFC); step(0, 0, 0); step(0, 0, 0);

    rand_steps(1500);

    // Asynchronous reset mid-freeze, between clock edges
    step(1, 0, 0); step(1, 0, 0);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_addr",  imem_addr, RST_PC);
    check("async_rst_valid", {31'b0, if_id_valid}, 32'h0);
    model_reset();
    exp_q.delete();
    @(posedge clk); @(posedge clk); #3;
    freeze = 1'b0; branch_taken = 1'b0;
    rst_n = 1'b1;
    step(0, 0, 0); step(0, 0, 0);

    rand_steps(1000);

    @(posedge clk); #3;
    if (exp_q.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL queue_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
